uart_param_core: RTL and testbench

Next-generation full-duplex UART core replacing the fixed 8N1 uart_core.
- Data width, parity mode, stop-bit count and RX oversampling ratio are parameters.
- Adds an RX input synchroniser, false-start rejection, and parity/framing error reporting.
- Sits between the system-side byte interface and the serial pins. The TX and RX halves share one baud-tick generator.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_param_core.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the parameterised UART core
// Purpose: parity mode, TX/RX state encodings and the baud divider calculation.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Clocks per oversample tick, floored, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running oversample tick generator
// Purpose: one-cycle tick every DIV clocks, shared by the TX and RX state machines.
// Ports: clk (rising edge), reset (async, active high), tick (1-cycle pulse).
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  // With DIV=1 the counter sits at zero and tick is permanently high.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_param_core.sv
// rtl/uart_param_core.sv - full-duplex UART with configurable width, parity and stop bits
// Purpose: serialises tx_data onto tx_serial and deserialises rx_serial into rx_data,
//   reporting parity and framing errors; TX and RX share one baud tick.
// Ports: clk, reset (async, active high); tx_start/tx_data/tx_busy/tx_serial (transmit);
//   rx_serial (async input), rx_data/rx_done/rx_parity_err/rx_frame_err (receive).
module uart_param_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_serial,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int            DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam bit            HAS_PAR = (PARITY != int'(PAR_NONE));
  localparam logic          ODD     = (PARITY == int'(PAR_ODD));
  localparam int            TW      = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF  = TW'(OVERSAMPLE / 2 - 1);
  localparam int            BW      = $clog2(DATA_BITS);
  localparam logic [BW-1:0] B_LAST  = BW'(DATA_BITS - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e            tx_state, tx_state_n;
  logic [TW-1:0]        tx_tcnt, tx_tcnt_n;
  logic [BW-1:0]        tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_stop2, tx_stop2_n;
  logic                 tx_ser_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_tcnt   <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_par    <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_serial <= 1'b1;
    end else begin
      tx_state  <= tx_state_n;
      tx_tcnt   <= tx_tcnt_n;
      tx_bit    <= tx_bit_n;
      tx_sh     <= tx_sh_n;
      tx_par    <= tx_par_n;
      tx_stop2  <= tx_stop2_n;
      tx_serial <= tx_ser_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    tx_stop2_n = tx_stop2;
    if (tx_state == TX_IDLE) begin
      if (tx_start) begin
        tx_state_n = TX_START;
        tx_sh_n    = tx_data;
        tx_par_n   = (^tx_data) ^ ODD;
        tx_tcnt_n  = '0;
        tx_stop2_n = 1'b0;
      end
    end else if (tick) begin
      if (tx_tcnt != T_LAST) begin
        tx_tcnt_n = tx_tcnt + 1'b1;
      end else begin
        tx_tcnt_n = '0;
        case (tx_state)
          TX_START: begin
            tx_state_n = TX_DATA;
            tx_bit_n   = '0;
          end
          TX_DATA: begin
            // Shift so the next data bit is always in position 0.
            tx_sh_n = tx_sh >> 1;
            if (tx_bit == B_LAST) tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
            else                  tx_bit_n   = tx_bit + 1'b1;
          end
          TX_PARITY: tx_state_n = TX_STOP;
          TX_STOP: begin
            if (STOP_BITS == 2 && !tx_stop2) tx_stop2_n = 1'b1;
            else                             tx_state_n = TX_IDLE;
          end
          default: tx_state_n = TX_IDLE;
        endcase
      end
    end
    // Line level registered from the next state so tx_serial is glitch-free.
    case (tx_state_n)
      TX_START:  tx_ser_n = 1'b0;
      TX_DATA:   tx_ser_n = tx_sh_n[0];
      TX_PARITY: tx_ser_n = tx_par_n;
      default:   tx_ser_n = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_serial};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s = rx_sync[1];

  rx_state_e            rx_state, rx_state_n;
  logic [TW-1:0]        rx_tcnt, rx_tcnt_n;
  logic [BW-1:0]        rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_perr, rx_perr_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_done_n, rx_parity_err_n, rx_frame_err_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state      <= RX_IDLE;
      rx_tcnt       <= '0;
      rx_bit        <= '0;
      rx_sh         <= '0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_n;
      rx_tcnt       <= rx_tcnt_n;
      rx_bit        <= rx_bit_n;
      rx_sh         <= rx_sh_n;
      rx_perr       <= rx_perr_n;
      rx_data       <= rx_data_n;
      rx_done       <= rx_done_n;
      rx_parity_err <= rx_parity_err_n;
      rx_frame_err  <= rx_frame_err_n;
    end
  end

  always_comb begin
    rx_state_n      = rx_state;
    rx_tcnt_n       = rx_tcnt;
    rx_bit_n        = rx_bit;
    rx_sh_n         = rx_sh;
    rx_perr_n       = rx_perr;
    rx_data_n       = rx_data;
    rx_done_n       = 1'b0;
    rx_parity_err_n = rx_parity_err;
    rx_frame_err_n  = rx_frame_err;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_tcnt_n  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tcnt == T_HALF) begin
            // Mid start bit: a high line means the falling edge was a glitch.
            rx_tcnt_n  = '0;
            rx_bit_n   = '0;
            rx_perr_n  = 1'b0;
            rx_state_n = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: begin
        if (tick) begin
          if (rx_tcnt != T_LAST) begin
            rx_tcnt_n = rx_tcnt + 1'b1;
          end else begin
            rx_tcnt_n = '0;
            case (rx_state)
              RX_DATA: begin
                rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
                if (rx_bit == B_LAST) rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
                else                  rx_bit_n   = rx_bit + 1'b1;
              end
              RX_PARITY: begin
                rx_perr_n  = rx_s ^ (^rx_sh) ^ ODD;
                rx_state_n = RX_STOP;
              end
              default: begin
                rx_done_n       = 1'b1;
                rx_data_n       = rx_sh;
                rx_parity_err_n = rx_perr;
                rx_frame_err_n  = !rx_s;
                // A low stop bit (e.g. break) must not be re-read as new frames.
                rx_state_n      = rx_s ? RX_IDLE : RX_WAIT_IDLE;
              end
            endcase
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_param_core.sv
// tb/tb_uart_param_core.sv - directed self-checking bench for uart_param_core
module tb_uart_param_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_drv;
  logic       loop0;
  logic       rx0;
  logic [2:0] tst, tser, busy, done, perr, ferr;
  logic [7:0] txd0, rxd0, txd2, rxd2;
  logic [6:0] txd1, rxd1;

  int done_cnt[3] = '{0, 0, 0};
  int busy_cnt[3] = '{0, 0, 0};
  int n_cmp = 0;
  int n_err = 0;
  int b, bb;

  always #5 clk = ~clk;

  assign rx0 = loop0 ? tser[0] : rx_drv;

  uart_param_core #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u0 (
    .clk(clk), .reset(rst), .tx_start(tst[0]), .tx_data(txd0), .tx_busy(busy[0]),
    .tx_serial(tser[0]), .rx_serial(rx0), .rx_data(rxd0), .rx_done(done[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]));

  uart_param_core #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .OVERSAMPLE(16)) u1 (
    .clk(clk), .reset(rst), .tx_start(tst[1]), .tx_data(txd1), .tx_busy(busy[1]),
    .tx_serial(tser[1]), .rx_serial(tser[1]), .rx_data(rxd1), .rx_done(done[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]));

  uart_param_core #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                    .STOP_BITS(1), .OVERSAMPLE(16)) u2 (
    .clk(clk), .reset(rst), .tx_start(tst[2]), .tx_data(txd2), .tx_busy(busy[2]),
    .tx_serial(tser[2]), .rx_serial(rx_drv), .rx_data(rxd2), .rx_done(done[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i]) done_cnt[i]++;
      if (busy[i]) busy_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    @(negedge clk);
    tst[i] = 1'b1;
    if (i == 0) txd0 = d;
    else        txd1 = d[6:0];
    @(negedge clk);
    tst[i] = 1'b0;
  endtask

  // Called right after send: samples each bit of the line at mid-bit.
  task automatic chk_line(input int i, input logic [15:0] bits, input int n, input string tag);
    repeat (8) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), 32'(tser[i]), 32'(bits[k]));
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic drive(input logic [15:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      rx_drv = bits[k];
      repeat (16) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_drv = 1'b1; loop0 = 1'b1; tst = '0;
    txd0 = '0; txd1 = '0; txd2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", 32'(tser), 32'h7);
    chk("rst_tx_busy", 32'(busy), 0);
    chk("rst_rx_done", 32'(done), 0);
    chk("rst_rx_data", 32'(rxd0), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_ferr", 32'(ferr), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: 8N1 loopback of 0xA5
    b = done_cnt[0]; bb = busy_cnt[0];
    send(0, 8'hA5);
    chk_line(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10, "t1_line");
    repeat (10) @(negedge clk);
    chk("t1_done_count", done_cnt[0] - b, 1);
    chk("t1_rx_data", 32'(rxd0), 32'hA5);
    chk("t1_perr", 32'(perr[0]), 0);
    chk("t1_ferr", 32'(ferr[0]), 0);
    chk("t1_busy_clocks", busy_cnt[0] - bb, 160);

    // 2: 7E2 loopback of 0x55, parity bit 0
    b = done_cnt[1]; bb = busy_cnt[1];
    send(1, 8'h55);
    chk_line(1, {5'h0, 2'b11, 1'b0, 7'h55, 1'b0}, 11, "t2_line");
    repeat (10) @(negedge clk);
    chk("t2_done_count", done_cnt[1] - b, 1);
    chk("t2_rx_data", 32'(rxd1), 32'h55);
    chk("t2_perr", 32'(perr[1]), 0);
    chk("t2_ferr", 32'(ferr[1]), 0);
    chk("t2_busy_clocks", busy_cnt[1] - bb, 176);

    // 3: odd parity, 0x3C with wrong parity bit 0
    b = done_cnt[2];
    drive({5'h0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (10) @(negedge clk);
    chk("t3_done_count", done_cnt[2] - b, 1);
    chk("t3_rx_data", 32'(rxd2), 32'h3C);
    chk("t3_perr", 32'(perr[2]), 1);
    chk("t3_ferr", 32'(ferr[2]), 0);

    // 4: 0x81 with low stop bit, then a 50-bit break, then 0x42
    loop0 = 1'b0;
    b = done_cnt[0];
    drive({6'h0, 1'b0, 8'h81, 1'b0}, 10);
    rx_drv = 1'b0;
    repeat (800) @(negedge clk);
    chk("t4_break_done_count", done_cnt[0] - b, 1);
    chk("t4_break_rx_data", 32'(rxd0), 32'h81);
    chk("t4_break_ferr", 32'(ferr[0]), 1);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    drive({6'h0, 1'b1, 8'h42, 1'b0}, 10);
    repeat (10) @(negedge clk);
    chk("t4_next_done_count", done_cnt[0] - b, 2);
    chk("t4_next_rx_data", 32'(rxd0), 32'h42);
    chk("t4_next_ferr", 32'(ferr[0]), 0);

    // 5: 4-clock glitch in idle, then 0x7E
    b = done_cnt[0];
    rx_drv = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("t5_glitch_done_count", done_cnt[0] - b, 0);
    chk("t5_glitch_rx_data_held", 32'(rxd0), 32'h42);
    drive({6'h0, 1'b1, 8'h7E, 1'b0}, 10);
    repeat (10) @(negedge clk);
    chk("t5_done_count", done_cnt[0] - b, 1);
    chk("t5_rx_data", 32'(rxd0), 32'h7E);

    // 6: ignored re-start during a frame, reset mid-frame, then 0x33
    loop0 = 1'b1;
    repeat (5) @(negedge clk);
    b = done_cnt[0];
    send(0, 8'h11);
    repeat (52) @(negedge clk);
    tst[0] = 1'b1; txd0 = 8'h22;
    @(negedge clk);
    tst[0] = 1'b0;
    repeat (35) @(negedge clk);
    chk("t6_bit4_of_0x11", 32'(tser[0]), 1);
    chk("t6_busy_mid", 32'(busy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx_serial", 32'(tser[0]), 1);
    chk("t6_rst_tx_busy", 32'(busy[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t6_no_done", done_cnt[0] - b, 0);
    chk("t6_rx_data_reset", 32'(rxd0), 0);
    send(0, 8'h33);
    repeat (180) @(negedge clk);
    chk("t6_done_count", done_cnt[0] - b, 1);
    chk("t6_rx_data", 32'(rxd0), 32'h33);
    chk("t6_ferr", 32'(ferr[0]), 0);
    chk("t6_busy_end", 32'(busy[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
